can_tx_mailbox_sched: RTL and testbench

//  Transmit scheduler in front of the CAN core (can_top TX path); holds NUM_MB host-loaded mailboxes.

---
 rtl/can_tx_mailbox_sched_pkg.sv | 29 ++
 rtl/can_tx_mailbox_sched_prio_select.sv | 30 +++
 rtl/can_tx_mailbox_sched.sv | 212 +++++++++++++++++++++
 tb/tb_can_tx_mailbox_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_mailbox_sched_pkg.sv
// rtl/can_tx_mailbox_sched_pkg.sv - shared types and priority key for the CAN TX mailbox scheduler
package can_tx_mailbox_sched_pkg;

  localparam int KEY_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_WAIT
  } sched_state_e;

  typedef struct packed {
    logic            ide;
    logic [10:0]     id_std;
    logic [17:0]     id_ext;
    logic            rtr;
    logic [3:0]      dlc;
    logic [7:0][7:0] data;
  } can_frame_t;

  // Lower key wins; the SRR slot is recessive for extended frames, so a standard
  // frame beats an extended one with the same base ID.
  function automatic logic [KEY_W-1:0] prio_key(input can_frame_t f);
    return {f.id_std, (f.ide ? 1'b1 : f.rtr), f.ide,
            (f.ide ? f.id_ext : 18'h0), (f.ide ? f.rtr : 1'b0)};
  endfunction

endpackage

// File: rtl/can_tx_mailbox_sched_prio_select.sv
// rtl/can_tx_mailbox_sched_prio_select.sv - min-key search over the eligible mailboxes
module can_tx_mailbox_sched_prio_select
  import can_tx_mailbox_sched_pkg::*;
#(
  parameter int NUM_MB = 4,
  localparam int MBW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1
) (
  input  logic [NUM_MB-1:0][KEY_W-1:0] keys,
  input  logic [NUM_MB-1:0]            mask,
  output logic [MBW-1:0]               win_idx,
  output logic                         win_valid
);

  logic [KEY_W-1:0] best;

  // Ascending scan with strict compare keeps the lower index on equal keys.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best      = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mask[i] && (!win_valid || keys[i] < best)) begin
        win_valid = 1'b1;
        win_idx   = MBW'(i);
        best      = keys[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_mailbox_sched.sv
// rtl/can_tx_mailbox_sched.sv - CAN TX mailbox store, priority scheduler and event reporting
module can_tx_mailbox_sched
  import can_tx_mailbox_sched_pkg::*;
#(
  parameter int NUM_MB     = 4,
  parameter int MAX_RETRY  = 3,
  parameter int START_HOLD = 8,
  localparam int MBW = (NUM_MB > 1) ? $clog2(NUM_MB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mb_wr_en,
  input  logic [MBW-1:0]    mb_wr_idx,
  input  logic              mb_wr_ide,
  input  logic [10:0]       mb_wr_id_std,
  input  logic [17:0]       mb_wr_id_ext,
  input  logic              mb_wr_rtr,
  input  logic [3:0]        mb_wr_dlc,
  input  logic [63:0]       mb_wr_data,
  input  logic [NUM_MB-1:0] mb_abort,
  input  logic              tx_done,
  input  logic              arb_lost,
  input  logic              tx_error,
  output logic              start_tx,
  output logic              ide,
  output logic [10:0]       id_std,
  output logic [17:0]       id_ext,
  output logic              rtr,
  output logic [3:0]        dlc,
  output logic [7:0]        tx_data_0,
  output logic [7:0]        tx_data_1,
  output logic [7:0]        tx_data_2,
  output logic [7:0]        tx_data_3,
  output logic [7:0]        tx_data_4,
  output logic [7:0]        tx_data_5,
  output logic [7:0]        tx_data_6,
  output logic [7:0]        tx_data_7,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [MBW-1:0]    mb_active_idx,
  output logic              busy,
  output logic              done_pulse,
  output logic              fail_pulse,
  output logic              abort_pulse,
  output logic [MBW-1:0]    evt_idx,
  output logic              wr_reject
);

  localparam int RCW = $clog2(MAX_RETRY + 2);
  localparam int HCW = $clog2(START_HOLD + 1);

  can_frame_t               mb_q [NUM_MB];
  logic [RCW-1:0]           retry_q [NUM_MB];
  logic [NUM_MB-1:0]        pend_q;
  sched_state_e             state_q, state_d;
  logic [HCW-1:0]           hold_q;
  logic [MBW-1:0]           act_q;
  logic                     abort_req_q;
  can_frame_t               out_q;

  can_frame_t               wr_frame;
  logic [NUM_MB-1:0][KEY_W-1:0] keys;
  logic [NUM_MB-1:0]        wr_oh, act_oh, sel_mask, abt_mask;
  logic [MBW-1:0]           win_idx, abt_idx;
  logic                     win_valid, abt_valid, abt_serve;
  logic                     wr_hits_active, wr_ok;
  logic                     wait_exit, act_abort, err_fail;
  logic                     exit_done, exit_abort, exit_fail, exit_evt;

  assign wr_frame = {mb_wr_ide, mb_wr_id_std, mb_wr_id_ext, mb_wr_rtr, mb_wr_dlc, mb_wr_data};
  assign busy     = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign start_tx = (state_q == ST_LAUNCH);

  assign wr_oh          = mb_wr_en ? (NUM_MB'(1) << mb_wr_idx) : '0;
  assign act_oh         = busy ? (NUM_MB'(1) << act_q) : '0;
  assign wr_hits_active = mb_wr_en && busy && (mb_wr_idx == act_q);
  assign wr_ok          = mb_wr_en && !wr_hits_active;

  // Mailboxes being aborted or rewritten this cycle are never picked for launch.
  assign sel_mask = pend_q & ~mb_abort & ~wr_oh;
  // A write to the same mailbox supersedes its abort; the active one waits for WAIT exit.
  assign abt_mask = mb_abort & pend_q & ~act_oh & ~wr_oh;

  assign wait_exit  = (state_q == ST_WAIT) && (tx_done || tx_error || arb_lost);
  assign act_abort  = abort_req_q || mb_abort[act_q];
  assign err_fail   = (int'(retry_q[act_q]) + 1) >= MAX_RETRY;
  assign exit_done  = (state_q == ST_WAIT) && tx_done;
  assign exit_abort = wait_exit && !tx_done && act_abort;
  assign exit_fail  = (state_q == ST_WAIT) && !tx_done && tx_error && !act_abort && err_fail;
  assign exit_evt   = exit_done || exit_abort || exit_fail;
  assign abt_serve  = abt_valid && !exit_evt;

  // Priority keys of every stored frame.
  always_comb begin
    keys = '0;
    for (int i = 0; i < NUM_MB; i++) keys[i] = prio_key(mb_q[i]);
  end

  // Lowest-index abort candidate; one served per cycle.
  always_comb begin
    abt_valid = 1'b0;
    abt_idx   = '0;
    for (int i = NUM_MB - 1; i >= 0; i--) begin
      if (abt_mask[i]) begin
        abt_valid = 1'b1;
        abt_idx   = MBW'(i);
      end
    end
  end

  can_tx_mailbox_sched_prio_select #(.NUM_MB(NUM_MB)) u_prio_select (
    .keys      (keys),
    .mask      (sel_mask),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // Next-state logic of the launch sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (|pend_q) state_d = ST_SELECT;
      ST_SELECT: state_d = win_valid ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: if (hold_q == HCW'(START_HOLD - 1)) state_d = ST_WAIT;
      ST_WAIT:   if (wait_exit) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, launch hold counter, active mailbox and frozen output fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      act_q       <= '0;
      abort_req_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_q == ST_LAUNCH) ? hold_q + 1'b1 : '0;
      if (state_q == ST_SELECT && win_valid) begin
        act_q <= win_idx;
        out_q <= mb_q[win_idx];
      end
      if (!busy || wait_exit)     abort_req_q <= 1'b0;
      else if (mb_abort[act_q])   abort_req_q <= 1'b1;
    end
  end

  // Mailbox contents, pending bits and retry counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_q[i]    <= '0;
        retry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_ok && mb_wr_idx == MBW'(i)) begin
          mb_q[i]    <= wr_frame;
          pend_q[i]  <= 1'b1;
          retry_q[i] <= '0;
        end else if (wait_exit && act_q == MBW'(i)) begin
          if (exit_evt) begin
            pend_q[i]  <= 1'b0;
            retry_q[i] <= '0;
          end else if (tx_error) begin
            retry_q[i] <= retry_q[i] + 1'b1;
          end
        end else if (abt_serve && abt_idx == MBW'(i)) begin
          pend_q[i]  <= 1'b0;
          retry_q[i] <= '0;
        end
      end
    end
  end

  // One-cycle event pulses; WAIT-exit events take precedence over aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pulse  <= 1'b0;
      fail_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      evt_idx     <= '0;
      wr_reject   <= 1'b0;
    end else begin
      done_pulse  <= exit_done;
      fail_pulse  <= exit_fail;
      abort_pulse <= exit_abort || abt_serve;
      wr_reject   <= wr_hits_active;
      if (exit_evt)       evt_idx <= act_q;
      else if (abt_serve) evt_idx <= abt_idx;
    end
  end

  assign mb_pending    = pend_q;
  assign mb_active_idx = act_q;
  assign ide           = out_q.ide;
  assign id_std        = out_q.id_std;
  assign id_ext        = out_q.id_ext;
  assign rtr           = out_q.rtr;
  assign dlc           = out_q.dlc;
  assign tx_data_0     = out_q.data[0];
  assign tx_data_1     = out_q.data[1];
  assign tx_data_2     = out_q.data[2];
  assign tx_data_3     = out_q.data[3];
  assign tx_data_4     = out_q.data[4];
  assign tx_data_5     = out_q.data[5];
  assign tx_data_6     = out_q.data[6];
  assign tx_data_7     = out_q.data[7];

endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// tb/tb_can_tx_mailbox_sched.sv - randomized scoreboard bench for the CAN TX mailbox scheduler
module tb_can_tx_mailbox_sched;
  import can_tx_mailbox_sched_pkg::*;

  localparam int NUM_MB     = 4;
  localparam int MBW        = 2;
  localparam int MAX_RETRY  = 3;
  localparam int START_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mb_wr_en = 1'b0;
  logic [MBW-1:0] mb_wr_idx = '0;
  logic mb_wr_ide = 1'b0;
  logic [10:0] mb_wr_id_std = '0;
  logic [17:0] mb_wr_id_ext = '0;
  logic mb_wr_rtr = 1'b0;
  logic [3:0] mb_wr_dlc = '0;
  logic [63:0] mb_wr_data = '0;
  logic [NUM_MB-1:0] mb_abort = '0;
  logic tx_done = 1'b0, arb_lost = 1'b0, tx_error = 1'b0;
  logic start_tx, ide, rtr, busy, done_pulse, fail_pulse, abort_pulse, wr_reject;
  logic [10:0] id_std;
  logic [17:0] id_ext;
  logic [3:0] dlc;
  logic [7:0] tx_data_0, tx_data_1, tx_data_2, tx_data_3, tx_data_4, tx_data_5, tx_data_6, tx_data_7;
  logic [NUM_MB-1:0] mb_pending;
  logic [MBW-1:0] mb_active_idx, evt_idx;

  always #5 clk = ~clk;

  can_tx_mailbox_sched #(.NUM_MB(NUM_MB), .MAX_RETRY(MAX_RETRY), .START_HOLD(START_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .mb_wr_en(mb_wr_en), .mb_wr_idx(mb_wr_idx), .mb_wr_ide(mb_wr_ide),
    .mb_wr_id_std(mb_wr_id_std), .mb_wr_id_ext(mb_wr_id_ext), .mb_wr_rtr(mb_wr_rtr),
    .mb_wr_dlc(mb_wr_dlc), .mb_wr_data(mb_wr_data), .mb_abort(mb_abort), .tx_done(tx_done),
    .arb_lost(arb_lost), .tx_error(tx_error), .start_tx(start_tx), .ide(ide), .id_std(id_std),
    .id_ext(id_ext), .rtr(rtr), .dlc(dlc), .tx_data_0(tx_data_0), .tx_data_1(tx_data_1),
    .tx_data_2(tx_data_2), .tx_data_3(tx_data_3), .tx_data_4(tx_data_4), .tx_data_5(tx_data_5),
    .tx_data_6(tx_data_6), .tx_data_7(tx_data_7), .mb_pending(mb_pending),
    .mb_active_idx(mb_active_idx), .busy(busy), .done_pulse(done_pulse), .fail_pulse(fail_pulse),
    .abort_pulse(abort_pulse), .evt_idx(evt_idx), .wr_reject(wr_reject)
  );

  typedef struct {int kind; int idx;} evt_t;   // kind: 0 done, 1 fail, 2 abort

  evt_t       ev_q[$];
  int         launch_q[$];
  can_frame_t launch_f[$];
  int         rej_q[$];

  can_frame_t m_frame [NUM_MB];
  bit         m_pend  [NUM_MB];
  int         m_retry [NUM_MB];
  int         act_idx = 0;
  bit         in_wait = 0;
  bit         abort_hold = 0;
  logic [NUM_MB-1:0] abort_bits = '0;

  int checks = 0, errors = 0;

  can_frame_t  cur_f = '0;
  logic        start_prev = 1'b0;
  logic [98:0] got_f;
  int          npulse, kind_got, ei;
  evt_t        ev;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic abort_run(input string name);
    chk(1'b0 == 1'b1 && start_tx === 1'bx, name, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // CAN arbitration field MSB-first (dominant 0), padded with dominant bits to 32.
  function automatic logic [31:0] arb_word(input can_frame_t f);
    logic [31:0] w;
    int n;
    w = '0;
    n = 0;
    for (int b = 10; b >= 0; b--) begin w[31-n] = f.id_std[b]; n++; end
    if (f.ide) begin
      w[31-n] = 1'b1; n++;            // SRR
      w[31-n] = 1'b1; n++;            // IDE
      for (int b = 17; b >= 0; b--) begin w[31-n] = f.id_ext[b]; n++; end
      w[31-n] = f.rtr;
    end else begin
      w[31-n] = f.rtr; n++;
      w[31-n] = 1'b0;                 // IDE
    end
    return w;
  endfunction

  function automatic int model_winner();
    int best;
    best = -1;
    for (int i = 0; i < NUM_MB; i++)
      if (m_pend[i] && (best < 0 || arb_word(m_frame[i]) < arb_word(m_frame[best]))) best = i;
    return best;
  endfunction

  function automatic logic [NUM_MB-1:0] model_pend_vec();
    logic [NUM_MB-1:0] v;
    for (int i = 0; i < NUM_MB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic can_frame_t rand_frame();
    can_frame_t f;
    case ($urandom_range(0, 4))
      0: f.id_std = 11'h100;
      1: f.id_std = 11'h123;
      2: f.id_std = 11'h3F7;
      3: f.id_std = 11'h101;
      default: f.id_std = 11'($urandom);
    endcase
    f.ide    = 1'($urandom_range(0, 1));
    f.id_ext = ($urandom_range(0, 1) == 1) ? 18'h0 : 18'($urandom);
    f.rtr    = 1'($urandom_range(0, 1));
    f.dlc    = 4'($urandom_range(0, 8));
    f.data   = {$urandom, $urandom};
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_next_launch();
    int w;
    w = model_winner();
    if (w >= 0) begin
      launch_q.push_back(w);
      launch_f.push_back(m_frame[w]);
      act_idx = w;
    end
  endtask

  task automatic do_write(input int idx, input can_frame_t f);
    mb_wr_en = 1'b1; mb_wr_idx = MBW'(idx);
    {mb_wr_ide, mb_wr_id_std, mb_wr_id_ext, mb_wr_rtr, mb_wr_dlc, mb_wr_data} = f;
    if (in_wait && idx == act_idx) rej_q.push_back(idx);
    else begin
      m_frame[idx] = f; m_pend[idx] = 1; m_retry[idx] = 0;
    end
    tick();
    mb_wr_en = 1'b0;
  endtask

  task automatic do_abort(input int idx);
    if (in_wait && idx == act_idx) begin
      abort_hold = 1; abort_bits[idx] = 1'b1;
      mb_abort = abort_bits;
    end else begin
      if (m_pend[idx]) begin
        ev_q.push_back('{2, idx});
        m_pend[idx] = 0; m_retry[idx] = 0;
      end
      mb_abort = abort_bits | (NUM_MB'(1) << idx);
    end
    tick();
    mb_abort = abort_bits;
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (!start_tx && n < 200) begin tick(); n++; end
    if (!start_tx) abort_run("launch_timeout");
    while (start_tx && n < 400) begin tick(); n++; end
    if (start_tx) abort_run("launch_hold_timeout");
    in_wait = 1;
  endtask

  task automatic core_respond();
    int r;
    bit d, e, a;
    r = $urandom_range(0, 99);
    d = (r < 50);
    e = (r >= 40 && r < 50) || (r >= 75);
    a = (r >= 50 && r < 75);
    if (d) begin
      ev_q.push_back('{0, act_idx}); m_pend[act_idx] = 0; m_retry[act_idx] = 0;
    end else if (abort_hold) begin
      ev_q.push_back('{2, act_idx}); m_pend[act_idx] = 0; m_retry[act_idx] = 0;
    end else if (e) begin
      m_retry[act_idx]++;
      if (m_retry[act_idx] == MAX_RETRY) begin
        ev_q.push_back('{1, act_idx}); m_pend[act_idx] = 0; m_retry[act_idx] = 0;
      end
    end
    tx_done = d; tx_error = e; arb_lost = a;
    tick();
    tx_done = 0; tx_error = 0; arb_lost = 0;
    abort_bits = '0; mb_abort = '0; abort_hold = 0; in_wait = 0;
    chk(mb_pending == model_pend_vec(), "pending_after_exit", mb_pending, model_pend_vec());
    push_next_launch();
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents a launch, event or reject.
  always @(negedge clk) begin
    if (rst_n) begin
      got_f = {ide, id_std, id_ext, rtr, dlc, tx_data_7, tx_data_6, tx_data_5, tx_data_4,
               tx_data_3, tx_data_2, tx_data_1, tx_data_0};
      if (start_tx && !start_prev) begin
        chk(launch_q.size() > 0, "launch_expected", launch_q.size(), 1);
        if (launch_q.size() > 0) begin
          ei    = launch_q.pop_front();
          cur_f = launch_f.pop_front();
          chk(mb_active_idx == MBW'(ei), "launch_idx", mb_active_idx, ei);
          chk(got_f == cur_f, "launch_fields", got_f, cur_f);
        end
      end else if (busy) begin
        chk(got_f == cur_f, "fields_stable", got_f, cur_f);
      end
      npulse = int'(done_pulse) + int'(fail_pulse) + int'(abort_pulse);
      if (npulse > 0) begin
        chk(npulse == 1, "single_event", npulse, 1);
        chk(ev_q.size() > 0, "event_expected", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
          ev = ev_q.pop_front();
          kind_got = done_pulse ? 0 : (fail_pulse ? 1 : 2);
          chk(kind_got == ev.kind && evt_idx == MBW'(ev.idx), "event",
              {kind_got[7:0], 6'h0, evt_idx}, {ev.kind[7:0], 6'h0, ev.idx[1:0]});
        end
      end
      if (wr_reject) begin
        chk(rej_q.size() > 0, "reject_expected", rej_q.size(), 1);
        if (rej_q.size() > 0) begin
          ei = rej_q.pop_front();
          chk(mb_active_idx == MBW'(ei), "reject_idx", mb_active_idx, ei);
        end
      end
    end
    start_prev = start_tx;
  end

  function automatic logic [200:0] all_outs();
    return {start_tx, ide, id_std, id_ext, rtr, dlc, tx_data_0, tx_data_1, tx_data_2, tx_data_3,
            tx_data_4, tx_data_5, tx_data_6, tx_data_7, mb_pending, mb_active_idx, busy,
            done_pulse, fail_pulse, abort_pulse, evt_idx, wr_reject};
  endfunction

  initial begin
    int op;
    for (int i = 0; i < NUM_MB; i++) begin m_frame[i] = '0; m_pend[i] = 0; m_retry[i] = 0; end
    #12;
    chk(all_outs() == '0, "reset_outputs", all_outs(), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int round = 0; round < 150; round++) begin
      if (model_winner() < 0) begin
        do_write($urandom_range(0, NUM_MB - 1), rand_frame());
        push_next_launch();
      end
      wait_launch();
      chk(mb_pending == model_pend_vec(), "pending_at_launch", mb_pending, model_pend_vec());
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        op = $urandom_range(0, 2);
        if (op == 0) do_write($urandom_range(0, NUM_MB - 1), rand_frame());
        else if (op == 1) do_abort($urandom_range(0, NUM_MB - 1));
        else tick();
        chk(mb_pending == model_pend_vec(), "pending_after_op", mb_pending, model_pend_vec());
      end
      tick();
      core_respond();
    end

    // Reset while the core owns a mailbox.
    if (model_winner() < 0) begin
      do_write(1, rand_frame());
      push_next_launch();
    end
    wait_launch();
    tick();
    rst_n = 1'b0;
    #1;
    chk(all_outs() == '0, "reset_mid_wait", all_outs(), 0);
    for (int i = 0; i < NUM_MB; i++) begin m_pend[i] = 0; m_retry[i] = 0; end
    in_wait = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk(mb_pending == '0 && !busy && !start_tx, "idle_after_reset", {mb_pending, busy, start_tx}, 0);

    chk(ev_q.size() == 0, "events_drained", ev_q.size(), 0);
    chk(launch_q.size() == 0, "launches_drained", launch_q.size(), 0);
    chk(rej_q.size() == 0, "rejects_drained", rej_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
